// File: rtl/vin_pkg.sv
// Shared definitions for the video-input pattern source: pattern codes and bar colours.
package vin_pkg;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_BARS  = 2'd3;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Map a 3-bit bar index to its colour, white first, black last.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        unique case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vin_timing.sv
// Raster timing: h/v counters plus combinational sync/valid decode of the current position.
module vin_timing #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 20,
    parameter int unsigned H_SYNC   = 10,
    parameter int unsigned H_BP     = 20,
    parameter int unsigned V_ACTIVE = 1200,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic [11:0] o_h_cnt,
    output logic [11:0] o_v_cnt,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_valid,
    output logic        o_frame_end
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic        w_h_last;
    logic        w_v_last;

    assign w_h_last = (r_h_cnt == 12'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == 12'(V_TOTAL - 1));

    // Advance the raster; disabled or reset parks it at the origin.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_valid     = (r_h_cnt < 12'(H_ACTIVE)) && (r_v_cnt < 12'(V_ACTIVE));
    assign o_hsync     = (r_h_cnt >= 12'(H_ACTIVE + H_FP)) &&
                         (r_h_cnt <  12'(H_ACTIVE + H_FP + H_SYNC));
    // Whole-line decode, so vsync only ever changes at h_cnt = 0.
    assign o_vsync     = (r_v_cnt >= 12'(V_ACTIVE + V_FP)) &&
                         (r_v_cnt <  12'(V_ACTIVE + V_FP + V_SYNC));
    assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/vin_patgen.sv
// Test-pattern video source: 48-bit RGB pixel pairs with hsync/vsync/valid, all registered.
// Optional build macro VIN_PATGEN_SCROLL_EN adds a per-frame horizontal scroll.
module vin_patgen
    import vin_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FP      = 20,
    parameter int unsigned H_SYNC    = 10,
    parameter int unsigned H_BP      = 20,
    parameter int unsigned V_ACTIVE  = 1200,
    parameter int unsigned V_FP      = 4,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 4,
    parameter int unsigned BAR_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern,
    input  logic [23:0] solid_rgb,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic [47:0] out_color,
    output logic        out_valid
);

    logic [11:0] w_h_cnt;
    logic [11:0] w_v_cnt;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_valid;
    logic        w_frame_end;
    logic        w_origin;
    logic [1:0]  w_pat;
    logic [23:0] w_solid;
    logic [7:0]  w_frame;
    logic [7:0]  w_x_even;
    logic [7:0]  w_x_odd;
    logic        w_y3;
    logic [11:0] w_bar_sum;
    logic [2:0]  w_bar_idx;
    logic [47:0] w_color;
    logic [1:0]  r_pat;
    logic [23:0] r_solid;

    vin_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_hsync     (w_hsync),
        .o_vsync     (w_vsync),
        .o_valid     (w_valid),
        .o_frame_end (w_frame_end)
    );

    assign w_origin = (w_h_cnt == 12'd0) && (w_v_cnt == 12'd0);
    // The origin pair already uses the newly sampled settings.
    assign w_pat    = w_origin ? pattern   : r_pat;
    assign w_solid  = w_origin ? solid_rgb : r_solid;

    // Capture pattern selection once per frame, at the raster origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat   <= PAT_SOLID;
            r_solid <= '0;
        end else if (enable && w_origin) begin
            r_pat   <= pattern;
            r_solid <= solid_rgb;
        end
    end

`ifdef VIN_PATGEN_SCROLL_EN
    logic [7:0] r_frame_cnt;

    // Count completed frames to drive the horizontal scroll.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (enable && w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign w_frame = r_frame_cnt;
`else
    assign w_frame = 8'd0;
`endif

    // Only the low byte of x matters for ramp (x[7:0]) and checker (x[3]).
    assign w_x_even  = {w_h_cnt[6:0], 1'b0} + {w_frame[6:0], 1'b0};
    assign w_x_odd   = w_x_even | 8'd1;
    assign w_y3      = (w_v_cnt & 12'h008) != 12'd0;
    assign w_bar_sum = w_h_cnt + {4'd0, w_frame};
    assign w_bar_idx = 3'(w_bar_sum >> BAR_SHIFT);

    // Colour for the current pair; forced black outside the active area.
    always_comb begin
        w_color = '0;
        if (w_valid) begin
            unique case (w_pat)
                PAT_SOLID: w_color = {w_solid, w_solid};
                PAT_RAMP:  w_color = {{3{w_x_even}}, {3{w_x_odd}}};
                PAT_CHECK: w_color = {(w_x_even[3] ^ w_y3) ? 24'hFFFFFF : 24'h000000,
                                      (w_x_odd[3]  ^ w_y3) ? 24'hFFFFFF : 24'h000000};
                default:   w_color = {2{bar_color(w_bar_idx)}};
            endcase
        end
    end

    // Register all outputs together so sync, valid and colour stay aligned.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_valid <= 1'b0;
            out_color <= '0;
        end else begin
            out_vsync <= w_vsync;
            out_hsync <= w_hsync;
            out_valid <= w_valid;
            out_color <= w_color;
        end
    end

endmodule

// File: tb/tb_vin_patgen.sv
// Directed bench for vin_patgen with a small 8x6 raster (48-cycle frame).
module tb_vin_patgen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern;
    logic [23:0] solid_rgb;
    logic        out_vsync;
    logic        out_hsync;
    logic [47:0] out_color;
    logic        out_valid;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference raster state (position about to be shown) and latched settings.
    int          mh = 0;
    int          mv = 0;
    int          mf = 0;
    logic [1:0]  lp = 2'd0;
    logic [23:0] ls = 24'd0;

    // Bookkeeping for sync checks.
    int   cyc = 0;
    int   vs_hi = 0;
    int   hs_rise_vs = 0;
    int   valid_cnt = 0;
    int   vs_rise_a = -1;
    int   vs_rise_b = -1;
    logic prev_hs = 1'b0;
    logic prev_vs = 1'b0;

    vin_patgen #(
        .H_ACTIVE  (4),
        .H_FP      (1),
        .H_SYNC    (2),
        .H_BP      (1),
        .V_ACTIVE  (3),
        .V_FP      (1),
        .V_SYNC    (1),
        .V_BP      (1),
        .BAR_SHIFT (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pattern   (pattern),
        .solid_rgb (solid_rgb),
        .out_vsync (out_vsync),
        .out_hsync (out_hsync),
        .out_color (out_color),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bar_ref(input int idx);
        case (idx % 8)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [47:0] color_ref(input logic [1:0] p, input logic [23:0] s,
                                              input int h, input int v, input int f);
        int          fo;
        int          xe;
        int          xo;
        logic [7:0]  re;
        logic [7:0]  ro;
        logic [23:0] ce;
        logic [23:0] co;
`ifdef VIN_PATGEN_SCROLL_EN
        fo = f;
`else
        fo = 0;
`endif
        if (!(h < 4 && v < 3)) return 48'd0;
        xe = 2 * h + 2 * fo;
        xo = xe + 1;
        re = 8'(xe);
        ro = 8'(xo);
        ce = (xe[3] ^ v[3]) ? 24'hFFFFFF : 24'h000000;
        co = (xo[3] ^ v[3]) ? 24'hFFFFFF : 24'h000000;
        case (p)
            2'd0: return {s, s};
            2'd1: return {{3{re}}, {3{ro}}};
            2'd2: return {ce, co};
            default: return {bar_ref(h + fo), bar_ref(h + fo)};
        endcase
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: predict from inputs at the edge, then compare #1 later.
    task automatic step();
        logic        ev;
        logic        eh;
        logic        evs;
        logic [47:0] ec;
        @(posedge clk);
        ev = 1'b0; eh = 1'b0; evs = 1'b0; ec = 48'd0;
        if (rst) begin
            mh = 0; mv = 0; mf = 0; lp = 2'd0; ls = 24'd0;
        end else if (!enable) begin
            mh = 0; mv = 0;
        end else begin
            if (mh == 0 && mv == 0) begin
                lp = pattern;
                ls = solid_rgb;
            end
            ev  = (mh < 4) && (mv < 3);
            eh  = (mh == 5) || (mh == 6);
            evs = (mv == 4);
            ec  = color_ref(lp, ls, mh, mv, mf);
            if (mh == 7) begin
                mh = 0;
                if (mv == 5) begin
                    mv = 0;
                    mf = (mf + 1) % 256;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
        #1;
        cyc++;
        check("valid", 48'(out_valid), 48'(ev));
        check("hsync", 48'(out_hsync), 48'(eh));
        check("vsync", 48'(out_vsync), 48'(evs));
        check("color", out_color, ec);
        if (out_vsync === 1'b1) vs_hi++;
        if (out_valid === 1'b1) valid_cnt++;
        if (out_vsync === 1'b1 && out_hsync === 1'b1 && prev_hs !== 1'b1) hs_rise_vs++;
        if (out_vsync === 1'b1 && prev_vs !== 1'b1) begin
            if (vs_rise_a < 0) vs_rise_a = cyc;
            else if (vs_rise_b < 0) vs_rise_b = cyc;
        end
        prev_hs = out_hsync;
        prev_vs = out_vsync;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        pattern   = 2'd1;
        solid_rgb = 24'd0;

        // Reset held for three cycles: everything low.
        repeat (3) step();
        rst = 1'b0;

        // Frame 0 (ramp). Switch to checker mid-frame; ramp must persist.
        valid_cnt = 0; vs_hi = 0; hs_rise_vs = 0;
        step();
        check("first_valid", 48'(out_valid), 48'd1);
        check("first_ramp", out_color, 48'h000000_010101);
        for (int i = 1; i < 48; i++) begin
            step();
            if (i == 2) check("ramp_h2", out_color, 48'h040404_050505);
            if (i == 5) check("ramp_blank", out_color, 48'd0);
            if (i == 20) pattern = 2'd2;
        end
        check("vsync_cycles", 48'(vs_hi), 48'd8);
        check("hsync_rise_in_vsync", 48'(hs_rise_vs), 48'd1);
        check("valid_per_frame", 48'(valid_cnt), 48'd12);

        // Frame 1 (checker), then switch to solid mid-frame.
        for (int i = 0; i < 48; i++) begin
            step();
            if (i == 12) begin
                pattern   = 2'd0;
                solid_rgb = 24'h123456;
            end
        end
        check("frame_period", 48'(vs_rise_b - vs_rise_a), 48'd48);

        // Frame 2 (solid).
        step();
        check("solid_pair0", out_color, 48'h123456_123456);
        for (int i = 1; i < 14; i++) step();

        // Reset mid-frame, restart with colour bars.
        rst = 1'b1;
        step();
        check("rst_mid_valid", 48'(out_valid), 48'd0);
        rst     = 1'b0;
        pattern = 2'd3;
        step();
        check("bars_pair0", out_color, 48'hFFFFFF_FFFFFF);
        step();
        check("bars_pair1", out_color, 48'hFFFF00_FFFF00);
        step();
        step();
        check("bars_pair3", out_color, 48'h00FF00_00FF00);
        for (int i = 0; i < 6; i++) step();

        // Drop enable mid-line, then re-enable: raster restarts at (0,0).
        enable = 1'b0;
        step();
        check("dis_valid", 48'(out_valid), 48'd0);
        check("dis_color", out_color, 48'd0);
        repeat (2) step();
        enable = 1'b1;
        step();
        check("reen_valid", 48'(out_valid), 48'd1);
        check("reen_color", out_color, 48'hFFFFFF_FFFFFF);
        repeat (3) step();

        // Second frame after reset with ramp: scroll shifts pair 0 when built in.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        pattern = 2'd1;
        repeat (48) step();
        step();
`ifdef VIN_PATGEN_SCROLL_EN
        check("frame1_ramp_pair0", out_color, 48'h020202_030303);
`else
        check("frame1_ramp_pair0", out_color, 48'h000000_010101);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
